// File: rtl/pipe_ctrl_gen.sv
// Pipeline control: thermometer stall arbitration, exception redirect, flush sequencer, stall watchdog, event counters.
// Stall/redirect decode is zero-cycle; counters and watchdog update one edge later; stall_o is the backpressure it issues.
module pipe_ctrl_gen #(
    parameter int          STAGES     = 6,
    parameter int          FLUSH_LEN  = 1,
    parameter logic [31:0] EXC_VEC    = 32'h80000380,
    parameter int          WDOG_LIMIT = 255,
    parameter int          CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    input  logic              wdog_clr_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              new_pc_valid_o,
    output logic              wdog_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int          FC_W      = $clog2(FLUSH_LEN) + 1;
    localparam int          WD_W      = $clog2(WDOG_LIMIT + 1);
    localparam logic [31:0] ERET_CODE = 32'h0000000e;
    localparam logic [WD_W:0] WD_LIM  = (WD_W+1)'(WDOG_LIMIT);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [31:0]       pc_q, pc_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              wdog_q, wdog_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [STAGES-1:0] therm;
    logic              therm_acc;
    logic [STAGES-1:0] stall_vec;
    logic              flush_now;
    logic              pc_vld;
    logic [31:0]       new_pc;
    logic [31:0]       target;

    // A stage stalls when it or any later stage asks, so everything behind the requester freezes too.
    always_comb begin
        therm     = '0;
        therm_acc = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            therm_acc = therm_acc | stallreq_i[k];
            therm[k]  = therm_acc;
        end
    end

    assign target = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VEC;

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_d        = pc_q;
        wd_d        = '0;
        wdog_d      = wdog_q & ~wdog_clr_i;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_vec   = '0;
        flush_now   = 1'b0;
        pc_vld      = 1'b0;
        new_pc      = '0;

        case (state_q)
            IDLE: begin
                if (excepttype_i != '0) begin
                    flush_now = 1'b1;
                    pc_vld    = 1'b1;
                    new_pc    = target;
                    pc_d      = target;
                    if (flush_cnt_q != '1)
                        flush_cnt_d = flush_cnt_q + CNT_W'(1);
                    if (FLUSH_LEN > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FC_W'(1);
                    end
                end else begin
                    stall_vec = therm;
                end
            end
            FLUSH: begin
                flush_now = 1'b1;
                new_pc    = pc_q;
                if (fcnt_q == FC_W'(FLUSH_LEN - 1)) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q + FC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase

        // Watchdog counts an unbroken run of stalled cycles; a trip restarts the run count.
        if (stall_vec != '0) begin
            if (stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (({1'b0, wd_q} + (WD_W+1)'(1)) == WD_LIM) begin
                wdog_d = 1'b1;
                wd_d   = '0;
            end else begin
                wd_d   = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            pc_q        <= '0;
            wd_q        <= '0;
            wdog_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pc_q        <= pc_d;
            wd_q        <= wd_d;
            wdog_q      <= wdog_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_o        = stall_vec;
    assign flush_o        = flush_now;
    assign new_pc_o       = new_pc;
    assign new_pc_valid_o = pc_vld;
    assign wdog_o         = wdog_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule
